// File: rtl/map_recovery_if.sv
// Bundles the signals exchanged between the rename-map recovery controller
// and its neighbours: the ROB (flush/retire), the architectural map (read port)
// and the speculative rename map table (write port).
//
// Modports:
//   slave  - the recovery controller: takes the flush/retire strobes and the
//            architectural-map read data; drives the read index, the map table
//            write port and the busy/done status.
//   master - the surrounding pipeline (or a testbench) driving the other side.
interface map_recovery_if #(
  parameter int AREG_W = 5,
  parameter int PREG_W = 6
);
  logic              mispredict_i;
  logic              retire_en_i;
  logic [AREG_W-1:0] retire_areg_idx_i;
  logic [PREG_W-1:0] retire_preg_i;
  logic [AREG_W-1:0] amap_read_idx_o;
  logic [PREG_W-1:0] amap_read_data_i;
  logic              mt_wr_en_o;
  logic [AREG_W-1:0] mt_wr_idx_o;
  logic [PREG_W-1:0] mt_wr_preg_o;
  logic              recovery_busy_o;
  logic              recovery_done_o;

  modport slave (
    input  mispredict_i, retire_en_i, retire_areg_idx_i, retire_preg_i,
    input  amap_read_data_i,
    output amap_read_idx_o, mt_wr_en_o, mt_wr_idx_o, mt_wr_preg_o,
    output recovery_busy_o, recovery_done_o
  );

  modport master (
    output mispredict_i, retire_en_i, retire_areg_idx_i, retire_preg_i,
    output amap_read_data_i,
    input  amap_read_idx_o, mt_wr_en_o, mt_wr_idx_o, mt_wr_preg_o,
    input  recovery_busy_o, recovery_done_o
  );
endinterface

// File: rtl/map_recovery_ctrl.sv
// Rename-map recovery controller. On a mispredict it walks the architectural
// map one entry per cycle and copies it into the speculative rename map table.
// Retires that land during the walk are merged so the table ends up equal to
// the architectural map as of the last copy cycle:
//   - retire to an already-copied entry  -> rewrite that entry (walk stalls)
//   - retire to the entry being copied   -> forward the retiring tag
//   - retire to a not-yet-copied entry   -> nothing; the walk reads it later
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active-low
//   bus  - map_recovery_if.slave (flush/retire in, amap read port,
//          map table write port, busy/done status)
module map_recovery_ctrl #(
  parameter int NUM_AREG = 32,
  parameter int AREG_W   = 5,
  parameter int PREG_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  map_recovery_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AREG_W:0] CNT_LAST = (AREG_W+1)'(NUM_AREG - 1);
  localparam logic [AREG_W:0] CNT_ONE  = (AREG_W+1)'(1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AREG_W:0] r_cnt;
  logic [AREG_W:0] w_cnt_nxt;
  logic            w_redo;
  logic            w_fwd;

  // Retire index compared against the walk pointer (zero-extended to cnt width).
  assign w_redo = bus.retire_en_i && ({1'b0, bus.retire_areg_idx_i} <  r_cnt);
  assign w_fwd  = bus.retire_en_i && ({1'b0, bus.retire_areg_idx_i} == r_cnt);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.mispredict_i) begin
          w_state_nxt = S_COPY;
          w_cnt_nxt   = '0;
        end
      end
      S_COPY: begin
        if (bus.mispredict_i) begin
          // Restart from entry 0; this cycle's write is still issued below.
          w_state_nxt = S_COPY;
          w_cnt_nxt   = '0;
        end else if (!w_redo) begin
          // A redo steals the write port, so the walk only advances otherwise.
          w_cnt_nxt = r_cnt + CNT_ONE;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_cnt_nxt = '0;
        if (bus.mispredict_i) begin
          w_state_nxt = S_COPY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.mt_wr_en_o      = 1'b0;
    bus.mt_wr_idx_o     = '0;
    bus.mt_wr_preg_o    = '0;
    bus.amap_read_idx_o = '0;
    bus.recovery_busy_o = 1'b0;
    bus.recovery_done_o = 1'b0;
    case (r_state)
      S_COPY: begin
        bus.recovery_busy_o = 1'b1;
        bus.mt_wr_en_o      = 1'b1;
        bus.amap_read_idx_o = r_cnt[AREG_W-1:0];
        if (w_redo) begin
          bus.mt_wr_idx_o  = bus.retire_areg_idx_i;
          bus.mt_wr_preg_o = bus.retire_preg_i;
        end else if (w_fwd) begin
          // The amap is written at the same edge, so its read data is stale.
          bus.mt_wr_idx_o  = r_cnt[AREG_W-1:0];
          bus.mt_wr_preg_o = bus.retire_preg_i;
        end else begin
          bus.mt_wr_idx_o  = r_cnt[AREG_W-1:0];
          bus.mt_wr_preg_o = bus.amap_read_data_i;
        end
      end
      S_DONE: begin
        bus.recovery_done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_map_recovery_ctrl.sv
// Bench for map_recovery_ctrl: directed recovery scenarios followed by random
// flush/retire traffic. The bench owns the architectural map and a shadow copy
// of the rename map table built from the controller's writes.
module tb_map_recovery_ctrl;
  localparam int NUM    = 32;
  localparam int AREG_W = 5;
  localparam int PREG_W = 6;

  typedef struct {
    bit is_done;
    int idx;
    int preg;
    int rd;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [PREG_W-1:0] amap   [NUM];
  logic [PREG_W-1:0] shadow [NUM];
  exp_t              q [$];

  // Reference model: recovery progress expressed as "entries copied so far".
  bit m_busy;
  bit m_done_due;
  int m_ptr;

  map_recovery_if #(.AREG_W(AREG_W), .PREG_W(PREG_W)) ifc ();

  map_recovery_ctrl #(.NUM_AREG(NUM), .AREG_W(AREG_W), .PREG_W(PREG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  assign ifc.amap_read_data_i = amap[ifc.amap_read_idx_o];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endfunction

  // One clock cycle: drive inputs, push what the controller must show this
  // cycle, then advance the architectural map at the clock edge.
  task automatic step(input bit mp, input bit ret, input int ridx, input int rpreg);
    exp_t e;
    ifc.mispredict_i      = mp;
    ifc.retire_en_i       = ret;
    ifc.retire_areg_idx_i = AREG_W'(ridx);
    ifc.retire_preg_i     = PREG_W'(rpreg);
    if (m_done_due) begin
      e = '{is_done: 1'b1, idx: 0, preg: 0, rd: 0};
      q.push_back(e);
      m_done_due = 1'b0;
      if (mp) begin
        m_busy = 1'b1;
        m_ptr  = 0;
      end
    end else if (m_busy) begin
      if (ret && ridx < m_ptr) begin
        e = '{is_done: 1'b0, idx: ridx, preg: rpreg, rd: m_ptr};
      end else begin
        e = '{is_done: 1'b0, idx: m_ptr,
              preg: (ret && ridx == m_ptr) ? rpreg : int'(amap[m_ptr]), rd: m_ptr};
        m_ptr++;
      end
      q.push_back(e);
      if (mp) begin
        m_ptr = 0;
      end else if (m_ptr == NUM) begin
        m_busy     = 1'b0;
        m_done_due = 1'b1;
      end
    end else if (mp) begin
      m_busy = 1'b1;
      m_ptr  = 0;
    end
    @(posedge clk);
    if (ret) amap[ridx] = PREG_W'(rpreg);
    #1;
  endtask

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic monitor_loop();
    exp_t e;
    int   mism;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (ifc.mt_wr_en_o || ifc.recovery_done_o) begin
          if (q.size() == 0) begin
            chk("queue_depth_at_output", q.size(), 1);
          end else begin
            e = q.pop_front();
            if (e.is_done) begin
              chk("done_pulse", int'(ifc.recovery_done_o), 1);
              chk("done_wr_en", int'(ifc.mt_wr_en_o), 0);
              chk("done_busy", int'(ifc.recovery_busy_o), 0);
              mism = 0;
              for (int i = 0; i < NUM; i++) if (shadow[i] != amap[i]) mism++;
              chk("table_vs_amap_mismatches", mism, 0);
            end else begin
              chk("wr_en", int'(ifc.mt_wr_en_o), 1);
              chk("copy_done", int'(ifc.recovery_done_o), 0);
              chk("copy_busy", int'(ifc.recovery_busy_o), 1);
              chk("wr_idx", int'(ifc.mt_wr_idx_o), e.idx);
              chk("wr_preg", int'(ifc.mt_wr_preg_o), e.preg);
              chk("amap_rd_idx", int'(ifc.amap_read_idx_o), e.rd);
              shadow[ifc.mt_wr_idx_o] = ifc.mt_wr_preg_o;
            end
          end
        end else begin
          chk("missing_output_queue", q.size(), 0);
          chk("idle_busy", int'(ifc.recovery_busy_o), 0);
          chk("idle_rd_idx", int'(ifc.amap_read_idx_o), 0);
          chk("idle_wr_idx", int'(ifc.mt_wr_idx_o), 0);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, int'(ifc.mt_wr_en_o), 0);
    chk({tag, "_wr_idx"}, int'(ifc.mt_wr_idx_o), 0);
    chk({tag, "_wr_preg"}, int'(ifc.mt_wr_preg_o), 0);
    chk({tag, "_rd_idx"}, int'(ifc.amap_read_idx_o), 0);
    chk({tag, "_busy"}, int'(ifc.recovery_busy_o), 0);
    chk({tag, "_done"}, int'(ifc.recovery_done_o), 0);
  endtask

  initial begin
    int  ridx;
    bit  mp;
    bit  ret;
    errors = 0;
    checks = 0;
    m_busy = 1'b0;
    m_done_due = 1'b0;
    m_ptr = 0;
    ifc.mispredict_i = 1'b0;
    ifc.retire_en_i = 1'b0;
    ifc.retire_areg_idx_i = '0;
    ifc.retire_preg_i = '0;
    for (int i = 0; i < NUM; i++) begin
      amap[i]   = PREG_W'(i);
      shadow[i] = '1;
    end
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_reset_outputs("por");
    @(posedge clk);
    #1 rst = 1'b1;
    fork
      monitor_loop();
    join_none
    run_idle(3);

    // Clean recovery over identity map.
    step(1'b1, 1'b0, 0, 0);
    run_idle(36);

    // Forward at cnt=5.
    step(1'b1, 1'b0, 0, 0);
    run_idle(5);
    step(1'b0, 1'b1, 5, 40);
    run_idle(36);

    // Redo at cnt=10.
    step(1'b1, 1'b0, 0, 0);
    run_idle(10);
    step(1'b0, 1'b1, 2, 33);
    run_idle(36);

    // Restart at cnt=20.
    step(1'b1, 1'b0, 0, 0);
    run_idle(20);
    step(1'b1, 1'b0, 0, 0);
    run_idle(36);

    // Back-to-back: mispredict during the done cycle.
    step(1'b1, 1'b0, 0, 0);
    run_idle(32);
    step(1'b1, 1'b0, 0, 0);
    run_idle(36);

    // Asynchronous reset in the middle of a walk at cnt=12.
    step(1'b1, 1'b0, 0, 0);
    run_idle(12);
    ifc.mispredict_i = 1'b0;
    chk("pre_reset_rd_idx", int'(ifc.amap_read_idx_o), m_ptr);
    rst = 1'b0;
    #1 check_reset_outputs("mid_copy_reset");
    m_busy = 1'b0;
    m_done_due = 1'b0;
    m_ptr = 0;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    run_idle(5);

    // Random flush/retire traffic over a scrambled map.
    for (int i = 0; i < NUM; i++) amap[i] = PREG_W'($urandom_range(63));
    for (int k = 0; k < 1500; k++) begin
      mp   = ($urandom_range(39) == 0);
      ret  = $urandom_range(1) == 1;
      ridx = $urandom_range(NUM - 1);
      if (m_busy && $urandom_range(3) == 0) ridx = m_ptr;
      step(mp, ret, ridx, $urandom_range(63));
    end

    for (int k = 0; k < 200 && (q.size() != 0 || m_busy || m_done_due); k++) begin
      step(1'b0, 1'b0, 0, 0);
    end
    chk("drain_pending_expectations", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
